// File: rtl/ex_iter_alu_if.sv
// Handshake bundle between the EX-stage issue logic and the iterative ALU.
// master drives the operation and consumes the result; slave is the ALU.
interface ex_iter_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ex_iter_alu.sv
// EX-stage ALU: single-cycle logic/arith/compare/LUI, shifts iterate one bit
// per cycle with valid/ready on both sides and a flush that squashes in-flight work.
module ex_iter_alu #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    ex_iter_alu_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_LUI  = 4'd10
    } alu_op_t;

    state_t          state;
    state_t          state_nxt;
    state_t          launch_state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_shift;
    logic [4:0]      cnt;
    logic [3:0]      sh_op;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic            is_shift;
    logic            accept;

    assign shamt    = bus.src2[4:0];
    assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    assign accept   = bus.in_valid && bus.in_ready;

    // A zero-distance shift is finished on acceptance, like any single-cycle op.
    assign launch_state = (is_shift && (shamt != 5'd0)) ? SHIFT : DONE;

    always_comb begin
        alu_res = bus.src1 + bus.src2;
        case (bus.op)
            OP_SUB:  alu_res = bus.src1 - bus.src2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.src1 < bus.src2)};
            OP_XOR:  alu_res = bus.src1 ^ bus.src2;
            OP_OR:   alu_res = bus.src1 | bus.src2;
            OP_AND:  alu_res = bus.src1 & bus.src2;
            OP_LUI:  alu_res = bus.src2;
            default: alu_res = bus.src1 + bus.src2;
        endcase
    end

    always_comb begin
        case (sh_op)
            OP_SLL:  acc_shift = {acc[XLEN-2:0], 1'b0};
            OP_SRA:  acc_shift = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_shift = {1'b0, acc[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = launch_state;
            SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = accept ? launch_state : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == SHIFT);
    end

    assign bus.result = result_q;

    // Datapath registers may load on a flushed accept; the FSM discards that result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sh_op    <= '0;
            result_q <= '0;
        end else if (accept) begin
            if (is_shift) begin
                acc   <= bus.src1;
                cnt   <= shamt;
                sh_op <= bus.op;
                if (shamt == 5'd0) begin
                    result_q <= bus.src1;
                end
            end else begin
                result_q <= alu_res;
            end
        end else if (state == SHIFT) begin
            acc <= acc_shift;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                result_q <= acc_shift;
            end
        end
    end
endmodule

// File: tb/tb_ex_iter_alu.sv
// Directed bench for ex_iter_alu: a cycle-level reference model checked every
// cycle, plus literal expectations on results, latencies and stall behaviour.
module tb_ex_iter_alu;
    logic clk;
    logic rst;
    logic flush;

    ex_iter_alu_if #(.XLEN(32)) bus ();

    ex_iter_alu #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return sa >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_shift_op(input logic [3:0] o);
        return (o == 4'd2) || (o == 4'd6) || (o == 4'd7);
    endfunction

    // Reference model: one op in flight, counting down remaining shift cycles.
    bit          m_has  = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;

    always @(posedge clk) begin
        bit ev;
        bit er;
        bit acc;
        if (rst) begin
            m_has = 1'b0;
        end else begin
            ev  = m_has && (m_left == 0);
            er  = !m_has || (ev && bus.out_ready);
            acc = bus.in_valid && er;
            if (flush) begin
                m_has = 1'b0;
            end else begin
                if (m_has && (m_left > 0)) m_left--;
                else if (ev && bus.out_ready) m_has = 1'b0;
                if (acc) begin
                    m_has  = 1'b1;
                    m_res  = ref_alu(bus.op, bus.src1, bus.src2);
                    m_left = is_shift_op(bus.op) ? int'(bus.src2[4:0]) : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
            check("rst_busy",      {31'd0, bus.busy},      32'd0);
            check("rst_result",    bus.result,             32'd0);
        end else begin
            ev = m_has && (m_left == 0);
            check("mdl_out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
            check("mdl_busy",      {31'd0, bus.busy},      {31'd0, m_has && (m_left > 0)});
            check("mdl_in_ready",  {31'd0, bus.in_ready},  {31'd0, !m_has || (ev && bus.out_ready)});
            if (ev) check("mdl_result", bus.result, m_res);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.src1     = a;
        bus.src2     = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat,
                               input int exp_busy);
        int  lat   = 1;
        int  bcnt  = 0;
        bit  seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) bcnt++;
                @(posedge clk);
                lat++;
            end
        end
        check({name, "_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_res"}, bus.result, exp);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_busy"}, bcnt, exp_busy);
    endtask

    logic [3:0]  b2b_op  [6] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd10, 4'd15};
    logic [31:0] b2b_a   [6] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd3};
    logic [31:0] b2b_b   [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h12345000, 32'd4};
    logic [31:0] b2b_exp [6] = '{32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h12345000, 32'd7};

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted mid-shift.
        send(4'd2, 32'd3, 32'd20);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_busy",      {31'd0, bus.busy},      32'd0);
        check("async_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        send(4'd0, 32'd5, 32'd7);
        wait_result("add_after_rst", 32'd12, 1, 0);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = b2b_op[i];
            bus.src1     = b2b_a[i];
            bus.src2     = b2b_b[i];
            @(negedge clk);
            check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
            if (i > 0) begin
                check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
                check("b2b_result", bus.result, b2b_exp[i-1]);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last", bus.result, b2b_exp[5]);
        @(posedge clk);
        #1;

        // Iterative shifts.
        send(4'd7, 32'h80000000, 32'd31);
        wait_result("sra31", 32'hFFFFFFFF, 32, 31);
        @(posedge clk);
        #1;
        send(4'd6, 32'h80000000, 32'd31);
        wait_result("srl31", 32'h00000001, 32, 31);
        @(posedge clk);
        #1;
        send(4'd2, 32'd1, 32'h00000024);
        wait_result("sll4", 32'h00000010, 5, 4);
        @(posedge clk);
        #1;
        send(4'd2, 32'hDEADBEEF, 32'd0);
        wait_result("sll0", 32'hDEADBEEF, 1, 0);
        @(posedge clk);
        #1;

        // Backpressure.
        bus.out_ready = 1'b0;
        send(4'd5, 32'hF0F0F0F0, 32'hFFFF0000);
        wait_result("xor_bp", 32'h0F0FF0F0, 1, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.src1     = 32'd1;
        bus.src2     = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_result", bus.result, 32'h0F0FF0F0);
            check("bp_in_ready",    {31'd0, bus.in_ready},  32'd0);
            check("bp_out_valid",   {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("bp_next_result", bus.result, 32'd3);
        @(posedge clk);
        #1;

        // Flush mid-shift with a simultaneous ADD, re-presented afterwards.
        send(4'd6, 32'hFFFF0000, 32'd10);
        repeat (2) @(posedge clk);
        #1;
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.src1     = 32'd10;
        bus.src2     = 32'd20;
        @(negedge clk);
        check("flush_cycle_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flushed_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flushed_busy",  {31'd0, bus.busy},      32'd0);
        check("flushed_ready", {31'd0, bus.in_ready},  32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("readd_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("readd_result", bus.result, 32'd30);
        @(posedge clk);
        #1;

        // Accept in an IDLE flush cycle is dropped.
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.src1     = 32'd1;
        bus.src2     = 32'd1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("idle_flush_drop", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // flush together with out_ready in DONE ends in IDLE.
        bus.out_ready = 1'b0;
        send(4'd0, 32'd2, 32'd2);
        wait_result("add_pre_flush", 32'd4, 1, 0);
        @(posedge clk);
        #1;
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("done_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("done_flush_ready", {31'd0, bus.in_ready},  32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
